// File: rtl/mux_pkg.sv
// Shared select encodings and constants for the N-to-1 operand selector.
package mux_pkg;

    localparam logic [31:0] PC_INCR = 32'd4;

    typedef enum logic [1:0] {
        SEL_A     = 2'd0,
        SEL_B     = 2'd1,
        SEL_CONST = 2'd2,
        SEL_D     = 2'd3
    } sel4_e;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } occ_e;

endpackage

// File: rtl/mux_nto1_comb.sv
// Combinational N-to-1 selector; out-of-range selects fall back to channel 0.
module mux_nto1_comb
    import mux_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int N     = 4,
    parameter int SEL_W = 2
) (
    input  logic [N*WIDTH-1:0] data_in,
    input  logic [SEL_W-1:0]   sel,
    output logic [WIDTH-1:0]   data_out,
    output logic               oor
);

    localparam logic [SEL_W:0] N_L = (SEL_W+1)'(N);

    always_comb begin
        data_out = data_in[int'(SEL_A)*WIDTH +: WIDTH];
        oor      = ({1'b0, sel} >= N_L);
        for (int k = 0; k < N; k++) begin
            if (sel == SEL_W'(k)) begin
                data_out = data_in[k*WIDTH +: WIDTH];
            end
        end
    end

endmodule

// File: rtl/mux_nto1_reg.sv
// Registered N-to-1 selector with valid/ready handshake and sticky select error.
// MUX_NTO1_CONST_CHAN_EN replaces channel CONST_IDX with CONST_VAL.
module mux_nto1_reg
    import mux_pkg::*;
#(
    parameter int               WIDTH     = 32,
    parameter int               N         = 4,
    parameter int               SEL_W     = 2,
    parameter int               CONST_IDX = int'(SEL_CONST),
    parameter logic [WIDTH-1:0] CONST_VAL = WIDTH'(PC_INCR)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [N*WIDTH-1:0] Data_in,
    input  logic [SEL_W-1:0]   Sel,
    input  logic               in_valid,
    output logic               in_ready,
    output logic [WIDTH-1:0]   Data_out,
    output logic [SEL_W-1:0]   Sel_out,
    output logic               out_valid,
    input  logic               out_ready,
    output logic               sel_err
);

`ifdef MUX_NTO1_CONST_CHAN_EN
    localparam bit CONST_EN = 1'b1;
`else
    localparam bit CONST_EN = 1'b0;
`endif

    logic [N*WIDTH-1:0] chans;
    logic [WIDTH-1:0]   mux_out;
    logic               mux_oor;

    occ_e             occ_q, occ_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic [SEL_W-1:0] sel_q, sel_d;
    logic             err_q, err_d;
    logic             in_xfer, out_xfer;

    always_comb begin
        chans = Data_in;
        if (CONST_EN && CONST_IDX < N) begin
            chans[CONST_IDX*WIDTH +: WIDTH] = CONST_VAL;
        end
    end

    mux_nto1_comb #(
        .WIDTH (WIDTH),
        .N     (N),
        .SEL_W (SEL_W)
    ) u_comb (
        .data_in  (chans),
        .sel      (Sel),
        .data_out (mux_out),
        .oor      (mux_oor)
    );

    assign in_ready = (occ_q == ST_EMPTY) || out_ready;

    always_comb begin
        in_xfer  = in_valid && in_ready;
        out_xfer = (occ_q == ST_FULL) && out_ready;
        occ_d    = occ_q;
        data_d   = data_q;
        sel_d    = sel_q;
        err_d    = err_q;
        unique case (occ_q)
            ST_EMPTY: if (in_xfer) occ_d = ST_FULL;
            ST_FULL:  if (out_xfer && !in_xfer) occ_d = ST_EMPTY;
        endcase
        if (in_xfer) begin
            data_d = mux_out;
            sel_d  = Sel;
            if (mux_oor) err_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            occ_q  <= ST_EMPTY;
            data_q <= '0;
            sel_q  <= '0;
            err_q  <= 1'b0;
        end else begin
            occ_q  <= occ_d;
            data_q <= data_d;
            sel_q  <= sel_d;
            err_q  <= err_d;
        end
    end

    assign Data_out  = data_q;
    assign Sel_out   = sel_q;
    assign out_valid = (occ_q == ST_FULL);
    assign sel_err   = err_q;

endmodule

// File: tb/tb_mux_nto1_reg.sv
// Scoreboard bench: a 4-channel and a 3-channel instance share one stimulus stream.
module tb_mux_nto1_reg;

    logic         clk = 1'b0;
    logic         reset;
    logic [127:0] din;
    logic [1:0]   sel;
    logic         in_valid;
    logic         out_ready;

    logic         in_ready4, out_valid4, err4;
    logic [31:0]  dout4;
    logic [1:0]   sout4;
    logic         in_ready3, out_valid3, err3;
    logic [31:0]  dout3;
    logic [1:0]   sout3;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [31:0] d;
        logic [1:0]  s;
    } exp_t;

    exp_t q4[$];
    exp_t q3[$];
    logic err3_m = 1'b0;

    always #5 clk = ~clk;

    mux_nto1_reg #(.WIDTH(32), .N(4), .SEL_W(2)) dut4 (
        .clk       (clk),
        .reset     (reset),
        .Data_in   (din),
        .Sel       (sel),
        .in_valid  (in_valid),
        .in_ready  (in_ready4),
        .Data_out  (dout4),
        .Sel_out   (sout4),
        .out_valid (out_valid4),
        .out_ready (out_ready),
        .sel_err   (err4)
    );

    mux_nto1_reg #(.WIDTH(32), .N(3), .SEL_W(2)) dut3 (
        .clk       (clk),
        .reset     (reset),
        .Data_in   (din[95:0]),
        .Sel       (sel),
        .in_valid  (in_valid),
        .in_ready  (in_ready3),
        .Data_out  (dout3),
        .Sel_out   (sout3),
        .out_valid (out_valid3),
        .out_ready (out_ready),
        .sel_err   (err3)
    );

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] ref_sel(input logic [127:0] d,
                                            input int s, input int n);
        int k;
        k = (s < n) ? s : 0;
`ifdef MUX_NTO1_CONST_CHAN_EN
        if (k == 2) return 32'd4;
`endif
        return d[k*32 +: 32];
    endfunction

    // Monitor: compares visible state with the model, retires on output transfer.
    always @(negedge clk) begin
        if (reset) begin
            chk("valid4", {31'b0, out_valid4}, {31'b0, q4.size() != 0});
            chk("valid3", {31'b0, out_valid3}, {31'b0, q3.size() != 0});
            chk("ready4", {31'b0, in_ready4}, {31'b0, q4.size() == 0 || out_ready});
            chk("ready3", {31'b0, in_ready3}, {31'b0, q3.size() == 0 || out_ready});
            chk("err4", {31'b0, err4}, 32'd0);
            chk("err3", {31'b0, err3}, {31'b0, err3_m});
            if (q4.size() != 0) begin
                chk("data4", dout4, q4[0].d);
                chk("sel4", {30'b0, sout4}, {30'b0, q4[0].s});
            end
            if (q3.size() != 0) begin
                chk("data3", dout3, q3[0].d);
                chk("sel3", {30'b0, sout3}, {30'b0, q3[0].s});
            end
            if (q4.size() != 0 && out_ready) begin
                void'(q4.pop_front());
                void'(q3.pop_front());
            end
        end
    end

    task automatic step(input logic v, input logic [1:0] s,
                        input logic [127:0] d, input logic r,
                        output logic acc);
        exp_t e;
        @(posedge clk);
        #1;
        in_valid  = v;
        sel       = s;
        din       = d;
        out_ready = r;
        @(negedge clk);
        #2;
        acc = v && (q4.size() == 0);
        if (acc) begin
            e.s = s;
            e.d = ref_sel(d, int'(s), 4);
            q4.push_back(e);
            e.d = ref_sel(d, int'(s), 3);
            q3.push_back(e);
            if (s >= 2'd3) err3_m = 1'b1;
        end
    endtask

    localparam logic [127:0] CH = {32'h44444444, 32'h33333333,
                                   32'h22222222, 32'h11111111};

    initial begin
        logic acc;
        logic [127:0] rd;
        logic [1:0] rs;
        logic rv;
        reset     = 1'b0;
        din       = '0;
        sel       = '0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        #1;
        chk("rst_data", dout4, 32'd0);
        chk("rst_valid", {31'b0, out_valid4}, 32'd0);
        chk("rst_ready", {31'b0, in_ready4}, 32'd1);
        chk("rst_err3", {31'b0, err3}, 32'd0);
        @(negedge clk);
        #2;
        reset = 1'b1;

        step(1'b1, 2'd1, CH, 1'b1, acc);
        for (int i = 0; i < 3; i++) step(1'b1, 2'd3, CH, 1'b0, acc);
        step(1'b1, 2'd3, CH, 1'b1, acc);
        step(1'b0, 2'd0, CH, 1'b1, acc);

        for (int i = 0; i < 4; i++) step(1'b1, 2'(i), CH, 1'b1, acc);
        step(1'b1, 2'd2, {32'h0, 32'hDEADBEEF, 64'h0}, 1'b1, acc);
        step(1'b1, 2'd0, CH, 1'b1, acc);
        step(1'b0, 2'd0, CH, 1'b1, acc);

        // Held word discarded asynchronously, sticky error cleared.
        step(1'b1, 2'd2, CH, 1'b1, acc);
        @(posedge clk);
        #1;
        chk("pre_rst_valid", {31'b0, out_valid4}, 32'd1);
        in_valid = 1'b0;
        #1;
        reset = 1'b0;
        #1;
        chk("mid_rst_data", dout4, 32'd0);
        chk("mid_rst_sel", {30'b0, sout4}, 32'd0);
        chk("mid_rst_valid", {31'b0, out_valid4}, 32'd0);
        chk("mid_rst_err3", {31'b0, err3}, 32'd0);
        chk("mid_rst_ready", {31'b0, in_ready4}, 32'd1);
        q4.delete();
        q3.delete();
        err3_m = 1'b0;
        @(negedge clk);
        #2;
        reset = 1'b1;

        step(1'b1, 2'd1, CH, 1'b1, acc);
        for (int i = 0; i < 300; i++) begin
            rv = ($urandom_range(0, 3) != 0);
            rs = 2'($urandom);
            rd = {$urandom, $urandom, $urandom, $urandom};
            for (int t = 0; t < 30; t++) begin
                step(rv, rs, rd, (t > 20) || ($urandom_range(0, 2) != 0), acc);
                if (acc || !rv) break;
            end
        end
        for (int i = 0; i < 3; i++) step(1'b0, 2'd0, CH, 1'b1, acc);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
